// File: rtl/prgrm_sequencer_if.sv
// Bundles the signals between the core control FSM and the program-counter
// sequencer, and gives each side a modport.
//   master : control side. Drives Wb_Stb, Crnt_Instrn, Flags and Clr_Err.
//            Observes PC, the PC-update strobes, Stk_Cnt and the sticky
//            stack error flags.
//   slave  : sequencer side. It has the opposite directions.
// The signal names follow the core's existing naming.
interface prgrm_sequencer_if #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4,
  parameter int NUM_FLAGS   = 3
);
  localparam int CNT_W = $clog2(STACK_DEPTH + 1);

  logic                 Wb_Stb;
  logic [31:0]          Crnt_Instrn;
  logic [NUM_FLAGS-1:0] Flags;
  logic                 Clr_Err;
  logic [ADDR_W-1:0]    PC;
  logic                 Incrmnt_PC;
  logic                 Ld_Brnch_Addr;
  logic                 Ld_Rtn_Addr;
  logic [CNT_W-1:0]     Stk_Cnt;
  logic                 Stk_Ovf;
  logic                 Stk_Unf;

  modport master (
    output Wb_Stb, Crnt_Instrn, Flags, Clr_Err,
    input  PC, Incrmnt_PC, Ld_Brnch_Addr, Ld_Rtn_Addr, Stk_Cnt, Stk_Ovf, Stk_Unf
  );

  modport slave (
    input  Wb_Stb, Crnt_Instrn, Flags, Clr_Err,
    output PC, Incrmnt_PC, Ld_Brnch_Addr, Ld_Rtn_Addr, Stk_Cnt, Stk_Ovf, Stk_Unf
  );
endinterface

// File: rtl/prgrm_sequencer.sv
// Program-counter sequencer. It owns the PC and a LIFO return-address stack.
// On each Wb_Stb (WRITEBACK) cycle it does exactly one of the following:
//   - pops a return address into the PC,
//   - loads a conditional jump or call target into the PC,
//   - increments the PC.
// Ports:
//   Clk   : core clock. All state changes on the rising edge.
//   Reset : synchronous, active-high. It has priority over every update.
//   seq   : prgrm_sequencer_if.slave.
//           Inputs  : Wb_Stb, Crnt_Instrn, Flags, Clr_Err.
//           Outputs : PC and Stk_Cnt (registered).
//                     Incrmnt_PC, Ld_Brnch_Addr, Ld_Rtn_Addr (combinational).
//                     Stk_Ovf and Stk_Unf (sticky).
module prgrm_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4,
  parameter int NUM_FLAGS   = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  prgrm_sequencer_if.slave  seq
);
  localparam int CNT_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

  // Instruction decode.
  logic       is_ctrl, is_jump, is_call, is_ret, invert;
  logic [7:0] cond_code;
  logic       cond_raw, cond_ok;

  assign is_ctrl   = (seq.Crnt_Instrn[31:30] == 2'b00);
  assign is_jump   = seq.Crnt_Instrn[29];
  assign is_call   = seq.Crnt_Instrn[28];
  assign is_ret    = seq.Crnt_Instrn[27];
  assign invert    = seq.Crnt_Instrn[25];
  assign cond_code = seq.Crnt_Instrn[23:16];

  // Flags[i] is selected by condition code i. Code 3F means "always".
  // Every other code is false.
  always_comb begin
    cond_raw = 1'b0;
    for (int i = 0; i < NUM_FLAGS; i++) begin
      if (cond_code == 8'(i)) cond_raw = seq.Flags[i];
    end
    if (cond_code == 8'h3F) cond_raw = 1'b1;
  end
  assign cond_ok = cond_raw ^ invert;

  // Stack bookkeeping.
  logic stk_empty, stk_full;
  assign stk_empty = (cnt_q == '0);
  assign stk_full  = (cnt_q == CNT_W'(STACK_DEPTH));

  // Strobes. Priority is: return, then taken jump/call, then increment.
  // A return on an empty stack falls through to increment.
  // A return instruction never branches, even if its jump or call bit is set.
  logic ret_cmd, ld_rtn, ld_brnch, incr;
  assign ret_cmd  = seq.Wb_Stb & is_ctrl & is_ret;
  assign ld_rtn   = ret_cmd & ~stk_empty;
  assign ld_brnch = seq.Wb_Stb & is_ctrl & ~is_ret & (is_jump | is_call) & cond_ok;
  assign incr     = seq.Wb_Stb & ~ld_rtn & ~ld_brnch;

  // A taken call pushes only when there is room. A full stack drops the
  // push, but the branch is still taken.
  logic push, set_ovf, set_unf;
  assign push    = ld_brnch & is_call & ~stk_full;
  assign set_ovf = ld_brnch & is_call & stk_full;
  assign set_unf = ret_cmd & stk_empty;

  // The write slot is the current count. The top entry is at count-1.
  // Truncating to IDX_W bits is safe: a push only happens below full,
  // and a pop only happens above empty.
  logic [IDX_W-1:0]  push_idx, pop_idx;
  logic [ADDR_W-1:0] pc_plus1, rtn_addr;
  assign push_idx = cnt_q[IDX_W-1:0];
  assign pop_idx  = push_idx - IDX_W'(1);
  assign pc_plus1 = pc_q + ADDR_W'(1);
  assign rtn_addr = stack_mem[pop_idx];

  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (ld_rtn) begin
      pc_d  = rtn_addr;
      cnt_d = cnt_q - CNT_W'(1);
    end else if (ld_brnch) begin
      pc_d = seq.Crnt_Instrn[ADDR_W-1:0];
      if (push) cnt_d = cnt_q + CNT_W'(1);
    end else if (incr) begin
      pc_d = pc_plus1;
    end
    // A new error in the same cycle wins over Clr_Err.
    if (seq.Clr_Err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (set_ovf) ovf_d = 1'b1;
    if (set_unf) unf_d = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // The stack contents are not reset. Only the count qualifies them.
  always_ff @(posedge Clk) begin
    if (!Reset && push) stack_mem[push_idx] <= pc_plus1;
  end

  assign seq.PC            = pc_q;
  assign seq.Stk_Cnt       = cnt_q;
  assign seq.Stk_Ovf       = ovf_q;
  assign seq.Stk_Unf       = unf_q;
  assign seq.Incrmnt_PC    = incr;
  assign seq.Ld_Brnch_Addr = ld_brnch;
  assign seq.Ld_Rtn_Addr   = ld_rtn;

  // The remaining instruction bits are not used by this block.
  logic unused_instr;
  assign unused_instr = ^seq.Crnt_Instrn;
endmodule

// File: tb/tb_prgrm_sequencer.sv
// Scoreboard bench for prgrm_sequencer with ADDR_W=8, STACK_DEPTH=4 and
// NUM_FLAGS=3.
// The driver applies one cycle at a time. It evaluates the sequencer rules
// on an abstract model (integer PC, queue as the stack) and queues the
// expected strobes and post-edge state. The monitor pops one entry per cycle
// and compares it against the DUT.
module tb_prgrm_sequencer;
  localparam int AW = 8;
  localparam int SD = 4;
  localparam int NF = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prgrm_sequencer_if #(.ADDR_W(AW), .STACK_DEPTH(SD), .NUM_FLAGS(NF)) bus ();

  prgrm_sequencer #(.ADDR_W(AW), .STACK_DEPTH(SD), .NUM_FLAGS(NF)) dut (
    .Clk   (clk),
    .Reset (rst),
    .seq   (bus.slave)
  );

  typedef struct {
    bit [2:0] strb;   // {rtn, brnch, incr}
    bit [7:0] pc;
    int       cnt;
    bit       ovf;
    bit       unf;
    string    tag;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_txn   = 0;

  // Reference model state.
  bit [7:0] m_pc = 8'h00;
  bit [7:0] m_stk[$];
  bit       m_ovf = 1'b0;
  bit       m_unf = 1'b0;

  localparam logic [31:0] NCF = 32'h4000_0000;

  task automatic chk(string nm, string tag, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s [%s]: got %0h, expected %0h", nm, tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(bit j, bit c, bit r, bit inv,
                                     bit [7:0] code, bit [7:0] tgt);
    mk = {2'b00, j, c, r, 1'b0, inv, 1'b0, code, 8'h00, tgt};
  endfunction

  // Drives one cycle and queues the expected result for it.
  task automatic step(bit r, bit stb, logic [31:0] ins, bit [2:0] fl,
                      bit clr, string tag);
    exp_t     e;
    bit       cf, cond, newo, newu;
    bit [7:0] code;
    @(negedge clk);
    rst             = r;
    bus.Wb_Stb      = stb;
    bus.Crnt_Instrn = ins;
    bus.Flags       = fl;
    bus.Clr_Err     = clr;

    cf   = (ins[31:30] == 2'b00);
    code = ins[23:16];
    if (code < 8'd3) cond = fl[code[1:0]];
    else             cond = (code == 8'h3F);
    if (ins[25]) cond = !cond;

    e.strb = 3'b000;
    if (stb) begin
      if (cf && ins[27])                        e.strb = (m_stk.size() > 0) ? 3'b100 : 3'b001;
      else if (cf && (ins[29] || ins[28]) && cond) e.strb = 3'b010;
      else                                      e.strb = 3'b001;
    end

    newo = 1'b0;
    newu = 1'b0;
    if (r) begin
      m_pc = 8'h00;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (e.strb[2]) m_pc = m_stk.pop_back();
      else if (e.strb[1]) begin
        if (ins[28]) begin
          if (m_stk.size() < SD) m_stk.push_back(m_pc + 8'd1);
          else                   newo = 1'b1;
        end
        m_pc = ins[7:0];
      end else if (e.strb[0]) begin
        if (cf && ins[27]) newu = 1'b1;
        m_pc = m_pc + 8'd1;
      end
      if (clr) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      if (newo) m_ovf = 1'b1;
      if (newu) m_unf = 1'b1;
    end
    e.pc  = m_pc;
    e.cnt = m_stk.size();
    e.ovf = m_ovf;
    e.unf = m_unf;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Literal check of the PC right after the edge that ends the last step.
  task automatic expect_pc(string tag, bit [7:0] v);
    @(posedge clk);
    #1;
    chk("pc_literal", tag, int'(bus.PC), int'(v));
  endtask

  // Monitor: samples the strobes mid-cycle, then the state after the edge.
  initial begin
    exp_t     e;
    bit [2:0] s;
    forever begin
      @(negedge clk);
      #2;
      s = {bus.Ld_Rtn_Addr, bus.Ld_Brnch_Addr, bus.Incrmnt_PC};
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_txn++;
        chk("strobes", e.tag, int'(s), int'(e.strb));
        chk("pc", e.tag, int'(bus.PC), int'(e.pc));
        chk("stk_cnt", e.tag, int'(bus.Stk_Cnt), e.cnt);
        chk("stk_ovf", e.tag, int'(bus.Stk_Ovf), int'(e.ovf));
        chk("stk_unf", e.tag, int'(bus.Stk_Unf), int'(e.unf));
        $display("[TB] txn %0d %s strb=%b pc=%02h cnt=%0d ovf=%0b unf=%0b",
                 n_txn, e.tag, s, bus.PC, bus.Stk_Cnt, bus.Stk_Ovf, bus.Stk_Unf);
      end
    end
  end

  initial begin
    bit [7:0]    codes [6];
    logic [31:0] ins;
    bit [7:0]    cd;
    int          k;
    codes = '{8'h00, 8'h01, 8'h02, 8'h3F, 8'h07, 8'h00};
    bus.Wb_Stb      = 1'b0;
    bus.Crnt_Instrn = NCF;
    bus.Flags       = 3'b000;
    bus.Clr_Err     = 1'b0;

    // Reset, then sequential increments.
    step(1, 0, NCF, 3'b000, 0, "reset");
    step(0, 0, NCF, 3'b000, 0, "idle");
    expect_pc("idle_pc0", 8'h00);
    for (int i = 0; i < 3; i++) step(0, 1, NCF | 32'h1234, 3'b000, 0, "seq_inc");
    expect_pc("seq_pc3", 8'h03);

    // Jump on Zero, both with and without the condition inverted.
    step(0, 1, mk(1, 0, 0, 0, 8'h3F, 8'h05), 3'b000, 0, "jmp_to5");
    step(0, 1, mk(1, 0, 0, 0, 8'h01, 8'h40), 3'b010, 0, "jz_taken");
    expect_pc("jz_pc40", 8'h40);
    step(0, 1, mk(1, 0, 0, 0, 8'h3F, 8'h05), 3'b000, 0, "jmp_to5b");
    step(0, 1, mk(1, 0, 0, 1, 8'h01, 8'h40), 3'b010, 0, "jz_inv");
    expect_pc("jz_inv_pc6", 8'h06);
    step(0, 1, mk(1, 0, 0, 1, 8'h3F, 8'h40), 3'b111, 0, "never");

    // Call, then return.
    step(0, 1, mk(1, 0, 0, 0, 8'h3F, 8'h10), 3'b000, 0, "jmp_to10");
    step(0, 1, mk(0, 1, 0, 0, 8'h3F, 8'h80), 3'b000, 0, "call80");
    expect_pc("call_pc80", 8'h80);
    step(0, 1, mk(0, 0, 1, 0, 8'h00, 8'h00), 3'b000, 0, "ret");
    expect_pc("ret_pc11", 8'h11);

    // Five nested calls (the fifth overflows), then five returns
    // (the fifth underflows), then clear the errors.
    step(1, 0, NCF, 3'b000, 0, "reset2");
    for (int i = 0; i < 5; i++)
      step(0, 1, mk(0, 1, 0, 0, 8'h3F, 8'(8'h20 + i)), 3'b000, 0, "nest_call");
    for (int i = 0; i < 5; i++)
      step(0, 1, mk(0, 0, 1, 0, 8'h00, 8'h00), 3'b000, 0, "nest_ret");
    step(0, 0, NCF, 3'b000, 1, "clr_err");

    // Wraparound cases.
    step(0, 1, mk(1, 0, 0, 0, 8'h3F, 8'hFF), 3'b000, 0, "jmp_ff");
    step(0, 1, NCF, 3'b000, 0, "wrap_inc");
    expect_pc("wrap_pc00", 8'h00);
    step(0, 1, mk(1, 0, 0, 0, 8'h3F, 8'hFF), 3'b000, 0, "jmp_ff2");
    step(0, 1, mk(0, 1, 0, 0, 8'h3F, 8'h30), 3'b000, 0, "call_at_ff");
    step(0, 1, mk(0, 0, 1, 0, 8'h00, 8'h00), 3'b000, 0, "ret_to00");
    expect_pc("ret_pc00", 8'h00);

    // Undefined condition code; jump and call bits both set.
    step(0, 1, mk(1, 0, 0, 0, 8'h07, 8'h55), 3'b111, 0, "code7");
    step(0, 1, mk(1, 1, 0, 0, 8'h02, 8'h66), 3'b100, 0, "jc_both");

    // Reset asserted during a call cycle.
    step(0, 1, mk(0, 1, 0, 0, 8'h3F, 8'h70), 3'b000, 0, "call_a");
    step(0, 1, mk(0, 1, 0, 0, 8'h3F, 8'h71), 3'b000, 0, "call_b");
    step(1, 1, mk(0, 1, 0, 0, 8'h3F, 8'h72), 3'b000, 0, "rst_call");
    expect_pc("rst_call_pc0", 8'h00);

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      k  = $urandom_range(0, 5);
      cd = codes[$urandom_range(0, 5)];
      if ($urandom_range(0, 9) == 0) cd = 8'($urandom);
      case (k)
        0: ins = {2'($urandom_range(1, 3)), 30'($urandom)};
        1: ins = mk(1, 0, 0, 1'($urandom), cd, 8'($urandom));
        2: ins = mk(0, 1, 0, 1'($urandom), cd, 8'($urandom));
        3: ins = mk(0, 0, 1, 0, cd, 8'($urandom));
        4: ins = mk(1, 1, 0, 1'($urandom), cd, 8'($urandom));
        default: ins = {2'b00, 30'($urandom)};
      endcase
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) != 0), ins,
           3'($urandom), ($urandom_range(0, 19) == 0), "rand");
    end

    step(0, 0, NCF, 3'b000, 0, "drain");
    @(posedge clk);
    #2;
    chk("sb_drain", "end", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
